native_bus_dma: RTL and testbench

- Word-copy DMA engine that acts as an initiator (master) on the picorv32-native memory handshake (valid/ready/addr/wdata/wstrb/rdata).
- It is the other end of the protocol from the SoC's existing responders: it drives requests and waits on ready.
- The CPU programs it through a small responder-side register port. It then copies LEN words from SRC to DST through its master port, which is arbitrated externally onto the SoC bus.
- It raises a level interrupt on completion.

---
 rtl/native_bus_dma.sv | 210 +++++++++++++++++++++
 tb/tb_native_bus_dma.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/native_bus_dma.sv
// Word-copy DMA engine: responder register port plus a picorv32-native initiator port.
// Define DMA_FILL_EN to add the FILL register and the write-only fill mode.
module native_bus_dma #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int unsigned LEN_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic [31:0] s_rdata,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    output logic        irq_done
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_GAP, S_WR, S_WR_GAP} state_t;

    state_t             state_q, state_n;
    logic [31:0]        src_q, dst_q, src_cur_q, src_cur_n, dst_cur_q, dst_cur_n;
    logic [LEN_W-1:0]   len_q, cnt_q, cnt_n;
    logic [31:0]        buf_q, buf_n;
    logic               done_q, done_n, irq_en_q, irq_en_n, irq_done_n;
    logic               m_valid_n;
    logic [31:0]        m_addr_n, m_wdata_n;
    logic [3:0]         m_wstrb_n;
    logic               sel, wr_en, ctrl_wr, busy, start, len_nz;
    logic [2:0]         reg_idx;
    logic               fill_bit, fill_start, fill_mode;
    logic [31:0]        fill_val;
    logic               unused_bits;

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    assign sel         = s_valid && (s_addr[31:5] == BASE_ADDR[31:5]);
    assign s_ready     = sel;
    assign reg_idx     = s_addr[4:2];
    assign wr_en       = sel && (s_wstrb != 4'b0000);
    assign ctrl_wr     = wr_en && (reg_idx == 3'd3);
    assign busy        = (state_q != S_IDLE);
    assign start       = ctrl_wr && s_wdata[0] && !busy;
    assign len_nz      = (len_q != '0);
    assign irq_en_n    = ctrl_wr ? s_wdata[1] : irq_en_q;
    assign unused_bits = ^s_addr[1:0];

`ifdef DMA_FILL_EN
    logic        fill_q, fill_mode_q;
    logic [31:0] fill_val_q;

    // Fill configuration; the mode is latched at start so CTRL writes mid-run cannot disturb it
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q      <= 1'b0;
            fill_mode_q <= 1'b0;
            fill_val_q  <= '0;
        end else begin
            if (ctrl_wr) fill_q <= s_wdata[2];
            if (start && len_nz) fill_mode_q <= s_wdata[2];
            if (wr_en && !busy && reg_idx == 3'd4) fill_val_q <= apply_strb(fill_val_q, s_wdata, s_wstrb);
        end
    end

    assign fill_bit   = fill_q;
    assign fill_start = s_wdata[2];
    assign fill_mode  = fill_mode_q;
    assign fill_val   = fill_val_q;
`else
    assign fill_bit   = 1'b0;
    assign fill_start = 1'b0;
    assign fill_mode  = 1'b0;
    assign fill_val   = '0;
`endif

    // Programmer-visible registers
    always_ff @(posedge clk) begin
        if (reset) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
        end else begin
            if (wr_en && !busy) begin
                case (reg_idx)
                    3'd0:    src_q <= apply_strb(src_q, s_wdata, s_wstrb) & 32'hFFFF_FFFC;
                    3'd1:    dst_q <= apply_strb(dst_q, s_wdata, s_wstrb) & 32'hFFFF_FFFC;
                    3'd2:    len_q <= LEN_W'(apply_strb(32'(len_q), s_wdata, s_wstrb));
                    default: ;
                endcase
            end
            irq_en_q <= irq_en_n;
        end
    end

    always_comb begin
        s_rdata = '0;
        if (sel) begin
            case (reg_idx)
                3'd0:    s_rdata = src_q;
                3'd1:    s_rdata = dst_q;
                3'd2:    s_rdata = 32'(len_q);
                3'd3:    s_rdata = {23'd0, done_q, 5'd0, fill_bit, irq_en_q, busy};
                3'd4:    s_rdata = fill_val;
                default: s_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:   if (start && len_nz) state_n = fill_start ? S_WR : S_RD;
            S_RD:     if (m_ready) state_n = S_RD_GAP;
            S_RD_GAP: state_n = S_WR;
            S_WR:     if (m_ready) state_n = S_WR_GAP;
            S_WR_GAP: state_n = (cnt_q != '0) ? (fill_mode ? S_WR : S_RD) : S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Next values of the working registers and of the registered master outputs
    always_comb begin
        src_cur_n = src_cur_q;
        dst_cur_n = dst_cur_q;
        cnt_n     = cnt_q;
        buf_n     = buf_q;
        done_n    = done_q;
        m_valid_n = 1'b0;
        m_wstrb_n = 4'b0000;
        m_addr_n  = m_addr;
        m_wdata_n = m_wdata;
        if (ctrl_wr && s_wdata[8]) done_n = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && len_nz) begin
                    src_cur_n = src_q;
                    dst_cur_n = dst_q;
                    cnt_n     = len_q;
                    done_n    = 1'b0;
                end else if (start) begin
                    done_n = 1'b1;
                end
            end
            S_RD:     if (m_ready) buf_n = m_rdata;
            S_WR: begin
                if (m_ready) begin
                    src_cur_n = src_cur_q + 32'd4;
                    dst_cur_n = dst_cur_q + 32'd4;
                    cnt_n     = cnt_q - LEN_W'(1);
                end
            end
            S_WR_GAP: if (cnt_q == '0) done_n = 1'b1;
            default:  ;
        endcase
        if (state_n == S_RD) begin
            m_valid_n = 1'b1;
            m_addr_n  = src_cur_n;
        end else if (state_n == S_WR) begin
            m_valid_n = 1'b1;
            m_wstrb_n = 4'b1111;
            m_addr_n  = dst_cur_n;
            if (state_q != S_WR) m_wdata_n = (state_q == S_RD_GAP) ? buf_q : fill_val;
        end
        irq_done_n = done_n && irq_en_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_cur_q <= '0;
            dst_cur_q <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            done_q    <= 1'b0;
            m_valid   <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wstrb   <= 4'b0000;
            irq_done  <= 1'b0;
        end else begin
            src_cur_q <= src_cur_n;
            dst_cur_q <= dst_cur_n;
            cnt_q     <= cnt_n;
            buf_q     <= buf_n;
            done_q    <= done_n;
            m_valid   <= m_valid_n;
            m_addr    <= m_addr_n;
            m_wdata   <= m_wdata_n;
            m_wstrb   <= m_wstrb_n;
            irq_done  <= irq_done_n;
        end
    end

endmodule

// File: tb/tb_native_bus_dma.sv
// Directed bench for native_bus_dma: register-port vector table plus transfer sequences
// against a stallable responder model.
module tb_native_bus_dma;

    localparam logic [31:0] A_SRC  = 32'h0300_0000;
    localparam logic [31:0] A_DST  = 32'h0300_0004;
    localparam logic [31:0] A_LEN  = 32'h0300_0008;
    localparam logic [31:0] A_CTRL = 32'h0300_000C;
    localparam logic [31:0] A_FILL = 32'h0300_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        m_valid, m_ready;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        irq_done;

    native_bus_dma dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata), .irq_done(irq_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder model: read-only word memory, configurable stall count per beat
    logic [31:0] mem [256];
    int stall_cfg = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        if (m_valid && !m_ready) stall_cnt <= stall_cnt + 1;
        else                     stall_cnt <= 0;
    end
    assign m_ready = m_valid && (stall_cnt >= stall_cfg);
    assign m_rdata = mem[m_addr[9:2]];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          t_start;
        int          t_end;
    } beat_t;

    beat_t log_q[$];
    beat_t cur;
    logic  in_beat = 1'b0;
    int    valid_cnt = 0;

    // Beat monitor: logs handshakes and checks request stability during stalls
    always @(negedge clk) begin
        if (m_valid) begin
            valid_cnt++;
            if (!in_beat) begin
                cur.addr = m_addr; cur.data = m_wdata; cur.strb = m_wstrb;
                cur.t_start = cyc;
                in_beat = 1'b1;
            end else begin
                checks++;
                if (m_addr !== cur.addr || m_wdata !== cur.data || m_wstrb !== cur.strb) begin
                    failures++;
                    $display("FAIL stable_req: got addr=%h wdata=%h wstrb=%h required addr=%h wdata=%h wstrb=%h",
                             m_addr, m_wdata, m_wstrb, cur.addr, cur.data, cur.strb);
                end
            end
            if (m_ready) begin
                cur.t_end = cyc;
                log_q.push_back(cur);
                in_beat = 1'b0;
            end
        end else begin
            in_beat = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        @(negedge clk);
        s_valid = 1'b1; s_addr = a; s_wdata = d; s_wstrb = st;
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    endtask

    task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        s_valid = 1'b1; s_addr = a; s_wstrb = '0;
        #1 d = s_rdata;
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_addr = '0;
    endtask

    // Polls CTRL.done every cycle; lat is cycles since t0, or -1 on timeout
    task automatic wait_done(input int t0, output int lat, output logic irq_at_done);
        lat = -1;
        irq_at_done = 1'b0;
        s_valid = 1'b1; s_addr = A_CTRL; s_wstrb = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (s_rdata[8]) begin
                lat = cyc - t0;
                irq_at_done = irq_done;
                break;
            end
        end
        s_valid = 1'b0; s_addr = '0;
    endtask

    logic [31:0] exp_data [8];

    task automatic check_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                              input int n, input int dur);
        chk({tag, "_beats"}, 32'(log_q.size()), 32'(2 * n));
        if (log_q.size() == 2 * n) begin
            for (int k = 0; k < n; k++) begin
                chk({tag, "_rd_addr"}, log_q[2*k].addr, src + 32'(4 * k));
                chk({tag, "_rd_strb"}, 32'(log_q[2*k].strb), 32'h0);
                chk({tag, "_wr_addr"}, log_q[2*k+1].addr, dst + 32'(4 * k));
                chk({tag, "_wr_data"}, log_q[2*k+1].data, exp_data[k]);
                chk({tag, "_wr_strb"}, 32'(log_q[2*k+1].strb), 32'hF);
            end
            for (int j = 0; j < 2 * n; j++) begin
                chk({tag, "_beat_len"}, 32'(log_q[j].t_end - log_q[j].t_start), 32'(dur));
                if (j > 0) chk({tag, "_gap"}, 32'(log_q[j].t_start - log_q[j-1].t_end), 32'd2);
            end
        end
    endtask

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        bit          exp_ready;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, lat;
        logic        irqd;
        logic [31:0] rd;
        logic        found;
        int          vc0;
        logic [31:0] fill_exp;

`ifdef DMA_FILL_EN
        fill_exp = 32'hCAFE_F00D;
`else
        fill_exp = 32'h0;
`endif
        tbl[0]  = '{0, A_SRC,  32'h1234_5677, 4'hF, 32'h0, 1};
        tbl[1]  = '{1, A_SRC,  32'h0,         4'h0, 32'h1234_5674, 1};
        tbl[2]  = '{0, A_SRC,  32'hAABB_CCDD, 4'h2, 32'h0, 1};
        tbl[3]  = '{1, A_SRC,  32'h0,         4'h0, 32'h1234_CC74, 1};
        tbl[4]  = '{0, A_DST,  32'h0000_0203, 4'hF, 32'h0, 1};
        tbl[5]  = '{1, A_DST,  32'h0,         4'h0, 32'h0000_0200, 1};
        tbl[6]  = '{0, A_LEN,  32'hFFFF_0007, 4'hF, 32'h0, 1};
        tbl[7]  = '{1, A_LEN,  32'h0,         4'h0, 32'h0000_0007, 1};
        tbl[8]  = '{0, A_LEN,  32'h0000_0100, 4'h2, 32'h0, 1};
        tbl[9]  = '{1, A_LEN,  32'h0,         4'h0, 32'h0000_0107, 1};
        tbl[10] = '{0, A_FILL, 32'hCAFE_F00D, 4'hF, 32'h0, 1};
        tbl[11] = '{1, A_FILL, 32'h0,         4'h0, fill_exp, 1};
        tbl[12] = '{1, 32'h0300_001C, 32'h0,  4'h0, 32'h0, 1};
        tbl[13] = '{1, 32'h0300_0020, 32'h0,  4'h0, 32'h0, 0};
        tbl[14] = '{1, 32'h02FF_FFFC, 32'h0,  4'h0, 32'h0, 0};
        tbl[15] = '{0, 32'h0300_0020, 32'hDEAD_BEEF, 4'hF, 32'h0, 0};
        tbl[16] = '{1, A_SRC,  32'h0,         4'h0, 32'h1234_CC74, 1};
        tbl[17] = '{0, A_CTRL, 32'h0000_0002, 4'hF, 32'h0, 1};
        tbl[18] = '{1, A_CTRL, 32'h0,         4'h0, 32'h0000_0002, 1};
        tbl[19] = '{0, A_CTRL, 32'h0000_0000, 4'hF, 32'h0, 1};
        tbl[20] = '{1, A_CTRL, 32'h0,         4'h0, 32'h0000_0000, 1};

        for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | 32'(i);
        mem[8'h40] = 32'h11; mem[8'h41] = 32'h22; mem[8'h42] = 32'h33; mem[8'h43] = 32'h44;
        mem[8'hC0] = 32'hA1; mem[8'hC1] = 32'hB2;
        mem[8'hFE] = 32'h5A5A_0001; mem[8'hFF] = 32'h5A5A_0002; mem[8'h00] = 32'h5A5A_0003;

        reset = 1'b1; s_valid = 1'b0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        chk("rst_m_wdata", m_wdata, 32'h0);
        chk("rst_m_wstrb", 32'(m_wstrb), 32'h0);
        chk("rst_irq_done", 32'(irq_done), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        reg_rd(A_CTRL, rd); chk("rst_ctrl", rd, 32'h0);
        reg_rd(A_SRC, rd);  chk("rst_src", rd, 32'h0);

        // Register-port vector table
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            s_valid = 1'b1; s_addr = tbl[i].addr; s_wdata = tbl[i].data;
            s_wstrb = tbl[i].rd ? 4'h0 : tbl[i].strb;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(s_ready), 32'(tbl[i].exp_ready));
            if (tbl[i].rd) chk($sformatf("vec%0d_rdata", i), s_rdata, tbl[i].exp);
            @(posedge clk);
            #1;
            s_valid = 1'b0; s_wstrb = '0; s_addr = '0; s_wdata = '0;
        end

        // Basic zero-wait copy with interrupt
        reg_wr(A_SRC, 32'h100, 4'hF);
        reg_wr(A_DST, 32'h200, 4'hF);
        reg_wr(A_LEN, 32'd3, 4'hF);
        log_q.delete();
        reg_wr(A_CTRL, 32'h3, 4'hF);
        t0 = cyc;
        wait_done(t0, lat, irqd);
        chk("basic_latency", 32'(lat), 32'd12);
        chk("basic_irq_at_done", 32'(irqd), 32'h1);
        reg_rd(A_CTRL, rd); chk("basic_ctrl_done", rd, 32'h102);
        exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33;
        check_copy("basic", 32'h100, 32'h200, 3, 0);
        reg_rd(A_SRC, rd); chk("basic_src_kept", rd, 32'h100);
        reg_rd(A_LEN, rd); chk("basic_len_kept", rd, 32'd3);
        reg_wr(A_CTRL, 32'h100, 4'hF);
        chk("basic_irq_clear", 32'(irq_done), 32'h0);
        reg_rd(A_CTRL, rd); chk("basic_ctrl_clear", rd, 32'h0);

        // Wait states: five stall cycles per beat
        stall_cfg = 5;
        reg_wr(A_SRC, 32'h300, 4'hF);
        reg_wr(A_DST, 32'h380, 4'hF);
        reg_wr(A_LEN, 32'd2, 4'hF);
        log_q.delete();
        reg_wr(A_CTRL, 32'h3, 4'hF);
        t0 = cyc;
        wait_done(t0, lat, irqd);
        chk("wait_latency", 32'(lat), 32'd28);
        exp_data[0] = 32'hA1; exp_data[1] = 32'hB2;
        check_copy("wait", 32'h300, 32'h380, 2, 5);
        reg_wr(A_CTRL, 32'h100, 4'hF);
        stall_cfg = 0;

        // LEN=0: done immediately, no bus traffic
        reg_wr(A_LEN, 32'd0, 4'hF);
        log_q.delete();
        reg_wr(A_CTRL, 32'h1, 4'hF);
        reg_rd(A_CTRL, rd); chk("len0_done", rd, 32'h100);
        repeat (5) @(posedge clk);
        chk("len0_no_beats", 32'(log_q.size()), 32'd0);
        reg_wr(A_CTRL, 32'h100, 4'hF);

        // Busy protection: register write and restart during a LEN=4 copy are ignored
        reg_wr(A_SRC, 32'h100, 4'hF);
        reg_wr(A_DST, 32'h500, 4'hF);
        reg_wr(A_LEN, 32'd4, 4'hF);
        log_q.delete();
        reg_wr(A_CTRL, 32'h3, 4'hF);
        t0 = cyc;
        reg_wr(A_SRC, 32'hDEAD_0000, 4'hF);
        reg_wr(A_CTRL, 32'h3, 4'hF);
        reg_rd(A_SRC, rd); chk("busy_src_kept", rd, 32'h100);
        reg_rd(A_CTRL, rd); chk("busy_flag", rd & 32'h1, 32'h1);
        wait_done(t0, lat, irqd);
        chk("busy_latency", 32'(lat), 32'd16);
        repeat (10) @(posedge clk);
        exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h33; exp_data[3] = 32'h44;
        check_copy("busy", 32'h100, 32'h500, 4, 0);
        reg_wr(A_CTRL, 32'h100, 4'hF);

        // Address wrap at 2^32
        reg_wr(A_SRC, 32'hFFFF_FFF8, 4'hF);
        reg_wr(A_DST, 32'h600, 4'hF);
        reg_wr(A_LEN, 32'd3, 4'hF);
        log_q.delete();
        reg_wr(A_CTRL, 32'h1, 4'hF);
        t0 = cyc;
        wait_done(t0, lat, irqd);
        chk("wrap_latency", 32'(lat), 32'd12);
        exp_data[0] = 32'h5A5A_0001; exp_data[1] = 32'h5A5A_0002; exp_data[2] = 32'h5A5A_0003;
        check_copy("wrap", 32'hFFFF_FFF8, 32'h600, 3, 0);
        reg_wr(A_CTRL, 32'h100, 4'hF);

`ifdef DMA_FILL_EN
        // Fill mode: writes only, two cycles per word
        reg_wr(A_FILL, 32'hA5A5_A5A5, 4'hF);
        reg_wr(A_DST, 32'h400, 4'hF);
        reg_wr(A_LEN, 32'd2, 4'hF);
        log_q.delete();
        reg_wr(A_CTRL, 32'h5, 4'hF);
        t0 = cyc;
        wait_done(t0, lat, irqd);
        chk("fill_latency", 32'(lat), 32'd4);
        chk("fill_beats", 32'(log_q.size()), 32'd2);
        if (log_q.size() == 2) begin
            for (int k = 0; k < 2; k++) begin
                chk("fill_addr", log_q[k].addr, 32'h400 + 32'(4 * k));
                chk("fill_data", log_q[k].data, 32'hA5A5_A5A5);
                chk("fill_strb", 32'(log_q[k].strb), 32'hF);
            end
        end
        reg_wr(A_CTRL, 32'h100, 4'hF);
`else
        // Without the fill feature, CTRL bit2 is inert and the transfer is a copy
        reg_wr(A_SRC, 32'h100, 4'hF);
        reg_wr(A_DST, 32'h400, 4'hF);
        reg_wr(A_LEN, 32'd2, 4'hF);
        log_q.delete();
        reg_wr(A_CTRL, 32'h5, 4'hF);
        t0 = cyc;
        reg_rd(A_CTRL, rd); chk("nofill_ctrl", rd, 32'h1);
        wait_done(t0, lat, irqd);
        chk("nofill_latency", 32'(lat), 32'd8);
        exp_data[0] = 32'h11; exp_data[1] = 32'h22;
        check_copy("nofill", 32'h100, 32'h400, 2, 0);
        reg_wr(A_CTRL, 32'h100, 4'hF);
`endif

        // Reset during the first write beat aborts the transfer
        stall_cfg = 3;
        reg_wr(A_SRC, 32'h100, 4'hF);
        reg_wr(A_DST, 32'h700, 4'hF);
        reg_wr(A_LEN, 32'd3, 4'hF);
        reg_wr(A_CTRL, 32'h3, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_valid && m_wstrb == 4'hF) begin
                found = 1'b1;
                break;
            end
        end
        chk("rstmid_found_wr", 32'(found), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_m_valid", 32'(m_valid), 32'h0);
        chk("rstmid_m_wstrb", 32'(m_wstrb), 32'h0);
        chk("rstmid_irq", 32'(irq_done), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        vc0 = valid_cnt;
        reg_rd(A_CTRL, rd); chk("rstmid_ctrl", rd, 32'h0);
        reg_rd(A_SRC, rd);  chk("rstmid_src", rd, 32'h0);
        repeat (30) @(posedge clk);
        chk("rstmid_no_traffic", 32'(valid_cnt - vc0), 32'd0);
        chk("rstmid_irq_late", 32'(irq_done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
